mac_output_serializer: RTL

//  Output-side counterpart of the MAC input register stage. Captures each wide

---
 rtl/mac_output_serializer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mac_output_serializer.sv
// Streams each captured accumulator result out LSB byte first over an 8-bit
// ready/valid bus, with a one-entry pending buffer and a saturating drop counter.
module mac_output_serializer #(
    parameter int ACC_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ACC_WIDTH-1:0] acc_in,
    input  logic                 acc_valid_in,
    input  logic                 overflow_in,
    input  logic                 out_ready,
    output logic [7:0]           data_out,
    output logic                 data_valid_out,
    output logic [1:0]           byte_idx_out,
    output logic                 last_out,
    output logic                 overflow_out,
    output logic                 busy_out,
    output logic                 dropped_out,
    output logic [3:0]           drop_count_out
);

    localparam int         NUM_BYTES = ACC_WIDTH / 8;
    localparam logic [1:0] LAST_IDX  = 2'(NUM_BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   word_q, word_d;
    logic                   ovf_q, ovf_d;
    logic [1:0]             idx_q, idx_d;
    logic                   valid_q, valid_d;
    logic [7:0]             data_q, data_d;
    logic                   last_q, last_d;
    logic [ACC_WIDTH-1:0]   pend_q, pend_d;
    logic                   pend_ovf_q, pend_ovf_d;
    logic                   pend_full_q, pend_full_d;
    logic                   dropped_q, dropped_d;
    logic [3:0]             drop_cnt_q, drop_cnt_d;

    logic                   accept_s;
    logic                   last_accept_s;
    logic                   drop_s;
    logic [ACC_WIDTH-1:0]   byte_sh_s;

    assign accept_s      = valid_q & out_ready;
    assign last_accept_s = accept_s & (idx_q == LAST_IDX);

    // Next-state, capture, pending-buffer and drop bookkeeping.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        ovf_d       = ovf_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        pend_ovf_d  = pend_ovf_q;
        pend_full_d = pend_full_q;
        drop_s      = 1'b0;

        case (state_q)
            IDLE: begin
                if (acc_valid_in) begin
                    state_d = SEND;
                    word_d  = acc_in;
                    ovf_d   = overflow_in;
                    idx_d   = 2'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (last_accept_s) begin
                    // Pending word has priority; a coincident new result refills pending.
                    if (pend_full_q) begin
                        word_d = pend_q;
                        ovf_d  = pend_ovf_q;
                        idx_d  = 2'd0;
                        if (acc_valid_in) begin
                            pend_d     = acc_in;
                            pend_ovf_d = overflow_in;
                        end else begin
                            pend_full_d = 1'b0;
                        end
                    end else if (acc_valid_in) begin
                        word_d = acc_in;
                        ovf_d  = overflow_in;
                        idx_d  = 2'd0;
                    end else begin
                        state_d = IDLE;
                        ovf_d   = 1'b0;
                        idx_d   = 2'd0;
                    end
                end else begin
                    if (accept_s) begin
                        idx_d = idx_q + 2'd1;
                    end else begin
                        idx_d = idx_q;
                    end
                    if (acc_valid_in) begin
                        if (pend_full_q) begin
                            drop_s = 1'b1;
                        end else begin
                            pend_d      = acc_in;
                            pend_ovf_d  = overflow_in;
                            pend_full_d = 1'b1;
                        end
                    end else begin
                        drop_s = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                idx_d       = 2'd0;
                ovf_d       = 1'b0;
                pend_full_d = 1'b0;
            end
        endcase

        dropped_d = drop_s;
        if (drop_s && (drop_cnt_q != 4'd15)) begin
            drop_cnt_d = drop_cnt_q + 4'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Output-facing registers are derived from the next state so they change with it.
    always_comb begin
        byte_sh_s = word_d >> {idx_d, 3'b000};
        valid_d   = (state_d == SEND);
        if (valid_d) begin
            data_d = byte_sh_s[7:0];
            last_d = (idx_d == LAST_IDX);
        end else begin
            data_d = 8'd0;
            last_d = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            ovf_q       <= 1'b0;
            idx_q       <= 2'd0;
            valid_q     <= 1'b0;
            data_q      <= 8'd0;
            last_q      <= 1'b0;
            pend_q      <= '0;
            pend_ovf_q  <= 1'b0;
            pend_full_q <= 1'b0;
            dropped_q   <= 1'b0;
            drop_cnt_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            ovf_q       <= ovf_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            last_q      <= last_d;
            pend_q      <= pend_d;
            pend_ovf_q  <= pend_ovf_d;
            pend_full_q <= pend_full_d;
            dropped_q   <= dropped_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign data_out       = data_q;
    assign data_valid_out = valid_q;
    assign byte_idx_out   = idx_q;
    assign last_out       = last_q;
    assign overflow_out   = ovf_q;
    assign busy_out       = (state_q == SEND) | pend_full_q;
    assign dropped_out    = dropped_q;
    assign drop_count_out = drop_cnt_q;

endmodule
